// File: rtl/cdc_pkg.sv
// Shared types and constants for the toggle-handshake CDC launcher.
package cdc_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } tx_state_t;

  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/domain_synchronizer.sv
// Multi-flop synchronizer bringing an asynchronous signal into the clk domain.
module domain_synchronizer
  import cdc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] r_sync [SYNC_STAGES];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= data_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign data_o = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source-side launcher for a two-phase req/ack CDC: holds data_o stable while a
// request is outstanding and flags ack timeouts and unsolicited acks.
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic                  req_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ack_async_i,
  output logic                  timeout_o,
  output logic                  proto_err_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  tx_state_t             r_state,     w_state_d;
  logic                  r_req,       w_req_d;
  logic [DATA_WIDTH-1:0] r_data,      w_data_d;
  logic [CntW-1:0]       r_cnt,       w_cnt_d;
  logic                  r_timeout,   w_timeout_d;
  logic                  r_proto_err, w_proto_err_d;
  logic                  w_ack_sync;

  domain_synchronizer #(
    .DATA_WIDTH (1)
  ) u_ack_sync (
    .clk    (clk),
    .resetn (resetn),
    .data_i (ack_async_i),
    .data_o (w_ack_sync)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_req       <= 1'b0;
      r_data      <= '0;
      r_cnt       <= '0;
      r_timeout   <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_req       <= w_req_d;
      r_data      <= w_data_d;
      r_cnt       <= w_cnt_d;
      r_timeout   <= w_timeout_d;
      r_proto_err <= w_proto_err_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_req_d       = r_req;
    w_data_d      = r_data;
    w_cnt_d       = r_cnt;
    w_timeout_d   = r_timeout;
    w_proto_err_d = r_proto_err;
    case (r_state)
      IDLE: begin
        // Ack parity must match req while idle; a mismatch means an unsolicited ack.
        if (w_ack_sync != r_req) begin
          w_proto_err_d = 1'b1;
        end else if (valid_i) begin
          w_data_d  = data_i;
          w_req_d   = ~r_req;
          w_cnt_d   = '0;
          w_state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (w_ack_sync == r_req) begin
          w_state_d = IDLE;
        end else if (r_cnt != CntMax) begin
          w_cnt_d = r_cnt + 1'b1;
          if ((TIMEOUT_CYCLES != 0) && (w_cnt_d == CntMax)) begin
            w_timeout_d = 1'b1;
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (r_state == IDLE);
  end

  assign req_o       = r_req;
  assign data_o      = r_data;
  assign timeout_o   = r_timeout;
  assign proto_err_o = r_proto_err;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Self-checking bench for cdc_handshake_tx: latency, back-to-back, timeout,
// protocol error, async reset and disabled-timeout behaviour.
module tb_cdc_handshake_tx;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid1, ack1;
  logic [31:0] data1;
  logic        ready1, req1, timeout1, proto1;
  logic [31:0] dout1;
  logic        valid2, ack2;
  logic [31:0] data2;
  logic        ready2, req2, timeout2, proto2;
  logic [31:0] dout2;

  int n_tests = 0;
  int n_fail  = 0;
  int n_toggles = 0;
  int n_unstable = 0;
  bit auto_ack = 1'b0;

  logic [31:0] sb[$];

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] wiggle;
    logic        exp_req;
  } vec_t;
  vec_t vecs [3];

  always #5 clk = ~clk;

  cdc_handshake_tx #(
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (8)
  ) u_dut1 (
    .clk         (clk),
    .resetn      (resetn),
    .valid_i     (valid1),
    .data_i      (data1),
    .ready_o     (ready1),
    .req_o       (req1),
    .data_o      (dout1),
    .ack_async_i (ack1),
    .timeout_o   (timeout1),
    .proto_err_o (proto1)
  );

  cdc_handshake_tx #(
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (0)
  ) u_dut2 (
    .clk         (clk),
    .resetn      (resetn),
    .valid_i     (valid2),
    .data_i      (data2),
    .ready_o     (ready2),
    .req_o       (req2),
    .data_o      (dout2),
    .ack_async_i (ack2),
    .timeout_o   (timeout2),
    .proto_err_o (proto2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard pops on every req toggle; also flags data_o moving while busy.
  logic        prev_req  = 1'b0;
  logic        prev_rdy  = 1'b1;
  logic [31:0] prev_data = '0;
  always @(negedge clk) begin
    if (!resetn) begin
      prev_req  = 1'b0;
      prev_rdy  = 1'b1;
      prev_data = '0;
    end else begin
      if (req1 !== prev_req) begin
        n_toggles++;
        if (sb.size() == 0) begin
          check("sb_unexpected_toggle", 32'd1, 32'd0);
        end else begin
          check("sb_data", dout1, sb.pop_front());
        end
      end
      if (!prev_rdy && (dout1 !== prev_data)) n_unstable++;
      prev_req  = req1;
      prev_rdy  = ready1;
      prev_data = dout1;
    end
  end

  // Destination model: mirrors req back as ack four cycles after each toggle.
  always begin
    @(req1);
    if (auto_ack && resetn) begin
      repeat (4) @(posedge clk);
      #2;
      ack1 = req1;
    end
  end

  task automatic wait_accept(output bit ok);
    logic rdy;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      rdy = ready1;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (ready1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    bit          ok;
    int          tog0;
    int          n_to;
    logic        saved_req;
    logic [31:0] saved_data;

    vecs[0] = '{data: 32'h0000_0001, wiggle: 32'hFFFF_0001, exp_req: 1'b0};
    vecs[1] = '{data: 32'h0000_0002, wiggle: 32'h5555_AAAA, exp_req: 1'b1};
    vecs[2] = '{data: 32'h0000_0003, wiggle: 32'hAAAA_5555, exp_req: 1'b0};

    resetn = 1'b0;
    valid1 = 1'b0; data1 = '0; ack1 = 1'b0;
    valid2 = 1'b0; data2 = '0; ack2 = 1'b0;

    // Reset values
    #12;
    check("rst_ready", ready1, 1);
    check("rst_req", req1, 0);
    check("rst_data", dout1, 0);
    check("rst_timeout", timeout1, 0);
    check("rst_proto", proto1, 0);
    check("rst2_ready", ready2, 1);

    // Single transfer latency
    @(posedge clk); #3 resetn = 1'b1;
    valid1 = 1'b1; data1 = 32'hDEAD_BEEF;
    sb.push_back(32'hDEAD_BEEF);
    @(posedge clk); #1;
    check("lat_req", req1, 1);
    check("lat_data", dout1, 32'hDEAD_BEEF);
    check("lat_ready", ready1, 0);
    valid1 = 1'b0;
    repeat (4) @(posedge clk);
    #1 ack1 = 1'b1;
    for (int e = 6; e <= 8; e++) begin
      @(posedge clk); #1;
      check($sformatf("lat_ready_edge%0d", e), ready1, (e == 8) ? 1 : 0);
    end

    // Back-to-back with wiggled data while busy
    auto_ack = 1'b1;
    tog0 = n_toggles;
    valid1 = 1'b1;
    for (int v = 0; v < 3; v++) begin
      data1 = vecs[v].data;
      sb.push_back(vecs[v].data);
      wait_accept(ok);
      check($sformatf("b2b_accept%0d", v), ok, 1);
      check($sformatf("b2b_req%0d", v), req1, vecs[v].exp_req);
      check($sformatf("b2b_data%0d", v), dout1, vecs[v].data);
      data1 = vecs[v].wiggle;
      repeat (2) @(posedge clk);
      #1;
    end
    valid1 = 1'b0;
    wait_ready(ok);
    check("b2b_done", ok, 1);
    check("b2b_toggles", n_toggles - tog0, 3);
    check("b2b_no_timeout", timeout1, 0);

    // Timeout after 8 cycles, then late ack
    auto_ack = 1'b0;
    valid1 = 1'b1; data1 = 32'hA5A5_A5A5;
    sb.push_back(32'hA5A5_A5A5);
    wait_accept(ok);
    check("to_accept", ok, 1);
    valid1 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 7) check("to_not_yet", timeout1, 0);
      if (k == 8) begin
        check("to_set", timeout1, 1);
        check("to_ready", ready1, 0);
      end
    end
    repeat (3) @(posedge clk);
    #1 check("to_still_wait", ready1, 0);
    ack1 = req1;
    wait_ready(ok);
    check("to_late_ack", ok, 1);
    check("to_sticky", timeout1, 1);

    // Async reset mid-transfer
    valid1 = 1'b1; data1 = 32'h1234_5678;
    sb.push_back(32'h1234_5678);
    wait_accept(ok);
    check("rm_accept", ok, 1);
    valid1 = 1'b0;
    @(posedge clk); #3;
    resetn = 1'b0;
    ack1 = 1'b0;
    #1;
    check("rm_req", req1, 0);
    check("rm_data", dout1, 0);
    check("rm_ready", ready1, 1);
    check("rm_timeout", timeout1, 0);
    check("rm_proto", proto1, 0);
    @(posedge clk); #3 resetn = 1'b1;

    // Unsolicited ack in IDLE
    @(posedge clk); #1;
    saved_req  = req1;
    saved_data = dout1;
    ack1 = ~ack1;
    repeat (3) @(posedge clk);
    #1 check("pe_set", proto1, 1);
    repeat (2) @(posedge clk);
    #1;
    check("pe_sticky", proto1, 1);
    check("pe_req", req1, saved_req);
    check("pe_data", dout1, saved_data);

    // Disabled timeout
    valid2 = 1'b1; data2 = 32'hCAFE_0000;
    @(posedge clk); #1;
    check("nt_accept_ready", ready2, 0);
    check("nt_req", req2, 1);
    check("nt_data", dout2, 32'hCAFE_0000);
    valid2 = 1'b0;
    n_to = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      if (timeout2) n_to++;
    end
    check("nt_timeout_never", n_to, 0);
    check("nt_still_wait", ready2, 0);

    check("data_stable_while_busy", n_unstable, 0);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
